// File: rtl/video_stream_out.sv
// Raster video output: buffers an incoming pixel stream in a small FIFO, locks it to
// frame start, and drives RGB with registered hsync/vsync/de from free-running counters.
module video_stream_out #(
    parameter int DATA_W      = 24,
    parameter int HRES        = 640,
    parameter int HFP         = 16,
    parameter int HSYNC       = 96,
    parameter int HBP         = 48,
    parameter int VRES        = 480,
    parameter int VFP         = 10,
    parameter int VSYNC       = 2,
    parameter int VBP         = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int FIFO_DEPTH  = 16,
    parameter int FILL_THRESH = 8
) (
    input  logic              clk_pix,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] rgb_in,
    input  logic              rgb_in_valid,
    input  logic              sof_in,
    output logic              rgb_in_ready,
    output logic [DATA_W-1:0] rgb_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out,
    output logic              underflow,
    output logic              locked
);

    localparam int HTOTAL = HRES + HFP + HSYNC + HBP;
    localparam int VTOTAL = VRES + VFP + VSYNC + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;

    localparam logic [HW-1:0] H_ACT  = HW'(HRES);
    localparam logic [HW-1:0] H_SS   = HW'(HRES + HFP);
    localparam logic [HW-1:0] H_SE   = HW'(HRES + HFP + HSYNC);
    localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(VRES);
    localparam logic [VW-1:0] V_SS   = VW'(VRES + VFP);
    localparam logic [VW-1:0] V_SE   = VW'(VRES + VFP + VSYNC);
    localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
    localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_THRESH = LW'(FILL_THRESH);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;

    logic active, h_sync, v_sync, h_last, v_last;
    logic fifo_empty, fifo_full;
    logic wr_en, rd_en, flush, uf_event;

    assign h_last     = (h == H_LAST);
    assign v_last     = (v == V_LAST);
    assign active     = (h < H_ACT) && (v < V_ACT);
    assign h_sync     = (h >= H_SS) && (h < H_SE);
    assign v_sync     = (v >= V_SS) && (v < V_SE);
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_FULL);
    assign locked     = (state == RUN);

    // Raster counters free-run in every state; only reset restarts them.
    always_ff @(posedge clk_pix) begin
        if (!RST_N) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        rgb_in_ready = 1'b1;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        flush        = 1'b0;
        uf_event     = 1'b0;
        case (state)
            SYNC: begin
                // Everything but a start-of-frame beat is dropped; the FIFO stays empty.
                if (rgb_in_valid && sof_in) begin
                    wr_en     = 1'b1;
                    state_nxt = FILL;
                end else begin
                    flush = 1'b1;
                end
            end
            FILL: begin
                rgb_in_ready = !fifo_full;
                wr_en        = rgb_in_valid && !fifo_full;
                if (h_last && v_last && (level >= LVL_THRESH)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                rgb_in_ready = !fifo_full;
                wr_en        = rgb_in_valid && !fifo_full;
                if (active) begin
                    if (fifo_empty) begin
                        // Starved mid-picture: drop lock and discard whatever arrives now.
                        uf_event  = 1'b1;
                        flush     = 1'b1;
                        wr_en     = 1'b0;
                        state_nxt = SYNC;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: begin
                flush     = 1'b1;
                state_nxt = SYNC;
            end
        endcase
        if (!RST_N) begin
            rgb_in_ready = 1'b1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (wr_en) begin
            mem[wr_ptr] <= rgb_in;
        end
    end

    // Read data comes from the registered array, so a word written while empty is not visible that cycle.
    always_ff @(posedge clk_pix) begin
        if (!RST_N || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!RST_N) begin
            state     <= SYNC;
            rgb_out   <= '0;
            de_out    <= 1'b0;
            hsync_out <= !SYNC_POL;
            vsync_out <= !SYNC_POL;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            rgb_out   <= rd_en ? mem[rd_ptr] : '0;
            de_out    <= active;
            hsync_out <= h_sync ? SYNC_POL : !SYNC_POL;
            vsync_out <= v_sync ? SYNC_POL : !SYNC_POL;
            if (uf_event) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_stream_out.sv
// Bench for video_stream_out on a tiny 14x7 raster, checked against a queue-based
// model of the buffering/lock behaviour and arithmetic timing expectations.
module tb_video_stream_out;

    localparam int H_ACT = 8;
    localparam int HFP   = 2;
    localparam int HSY   = 2;
    localparam int HBP   = 2;
    localparam int V_ACT = 4;
    localparam int VFP   = 1;
    localparam int VSY   = 1;
    localparam int VBP   = 1;
    localparam int DEPTH = 16;
    localparam int THRESH = 8;
    localparam int HT = H_ACT + HFP + HSY + HBP;
    localparam int VT = V_ACT + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int HS0 = H_ACT + HFP;
    localparam int HS1 = H_ACT + HFP + HSY;
    localparam int VS0 = V_ACT + VFP;
    localparam int VS1 = V_ACT + VFP + VSY;

    localparam int M_SYNC = 0;
    localparam int M_FILL = 1;
    localparam int M_RUN  = 2;
    localparam int ST_SYNC = 0;

    logic        clk_pix = 1'b0;
    logic        RST_N;
    logic [23:0] rgb_in;
    logic        rgb_in_valid;
    logic        sof_in;
    logic        rgb_in_ready;
    logic [23:0] rgb_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;
    logic        underflow;
    logic        locked;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: frame position, lock mode, sticky underflow and buffered pixels.
    int          m_cnt;
    int          m_mode;
    logic        m_uf;
    logic [23:0] exp_q[$];
    logic        m_last_act;
    logic        m_obs_acc;

    video_stream_out #(
        .DATA_W(24), .HRES(H_ACT), .HFP(HFP), .HSYNC(HSY), .HBP(HBP),
        .VRES(V_ACT), .VFP(VFP), .VSYNC(VSY), .VBP(VBP),
        .SYNC_POL(1'b0), .FIFO_DEPTH(DEPTH), .FILL_THRESH(THRESH)
    ) dut (
        .clk_pix      (clk_pix),
        .RST_N        (RST_N),
        .rgb_in       (rgb_in),
        .rgb_in_valid (rgb_in_valid),
        .sof_in       (sof_in),
        .rgb_in_ready (rgb_in_ready),
        .rgb_out      (rgb_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .de_out       (de_out),
        .underflow    (underflow),
        .locked       (locked)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_mode = M_SYNC;
        m_uf   = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset(input int n);
        RST_N        = 1'b0;
        rgb_in_valid = 1'b0;
        sof_in       = 1'b0;
        rgb_in       = '0;
        #1;
        check("ready_in_reset", 32'(rgb_in_ready), 32'd1);
        repeat (n) @(posedge clk_pix);
        @(negedge clk_pix);
        check("rst_rgb", 32'(rgb_out), 32'd0);
        check("rst_de", 32'(de_out), 32'd0);
        check("rst_hsync", 32'(hsync_out), 32'd1);
        check("rst_vsync", 32'(vsync_out), 32'd1);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_h", 32'(dut.h), 32'd0);
        check("rst_v", 32'(dut.v), 32'd0);
        check("rst_level", 32'(dut.level), 32'd0);
        check("rst_state", 32'(dut.state), 32'(ST_SYNC));
        RST_N = 1'b1;
        model_reset();
    endtask

    // One pixel clock: check ready, drive a beat, advance the model, check the registered outputs.
    task automatic step(input logic vld, input logic sof, input logic [23:0] d);
        int          h, v;
        logic        act, rdy, acc;
        logic [23:0] e_rgb;
        #1;
        h   = m_cnt % HT;
        v   = (m_cnt / HT) % VT;
        act = (h < H_ACT) && (v < V_ACT);
        rdy = (m_mode == M_SYNC) || (exp_q.size() < DEPTH);
        check("ready", 32'(rgb_in_ready), 32'(rdy));
        m_obs_acc    = vld && rgb_in_ready;
        rgb_in_valid = vld;
        sof_in       = sof;
        rgb_in       = d;
        acc   = vld && rdy;
        e_rgb = '0;
        if (m_mode == M_RUN) begin
            if (act && exp_q.size() == 0) begin
                m_uf   = 1'b1;
                m_mode = M_SYNC;
            end else begin
                if (act) e_rgb = exp_q.pop_front();
                if (acc) exp_q.push_back(d);
            end
        end else if (m_mode == M_FILL) begin
            if (h == HT - 1 && v == VT - 1 && exp_q.size() >= THRESH) m_mode = M_RUN;
            if (acc) exp_q.push_back(d);
        end else if (acc && sof) begin
            exp_q.push_back(d);
            m_mode = M_FILL;
        end
        m_last_act = act;
        @(posedge clk_pix);
        @(negedge clk_pix);
        m_cnt++;
        check("rgb_out", 32'(rgb_out), 32'(e_rgb));
        check("de_out", 32'(de_out), 32'(act));
        check("hsync_out", 32'(hsync_out), 32'(!(h >= HS0 && h < HS1)));
        check("vsync_out", 32'(vsync_out), 32'(!(v >= VS0 && v < VS1)));
        check("locked", 32'(locked), 32'(m_mode == M_RUN));
        check("underflow", 32'(underflow), 32'(m_uf));
        check("level", 32'(dut.level), 32'(exp_q.size()));
    endtask

    initial begin
        int hs_low, vs_low, fed, act_cnt, guard, bp_acc;
        RST_N        = 1'b0;
        rgb_in       = '0;
        rgb_in_valid = 1'b0;
        sof_in       = 1'b0;
        model_reset();

        // Free-running timing with no input.
        do_reset(2);
        hs_low = 0;
        vs_low = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            step(1'b0, 1'b0, '0);
            if (i < HT && hsync_out == 1'b0) hs_low++;
            if (i < FT && vsync_out == 1'b0) vs_low++;
        end
        check("hsync_low_per_line", 32'(hs_low), 32'(HSY));
        check("vsync_low_per_frame", 32'(vs_low), 32'(VSY * HT));

        // Discard before sof, lock at frame boundary, then starve into underflow and relock.
        do_reset(2);
        repeat (3) step(1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 24'($urandom));
        step(1'b1, 1'b1, 24'hA00001);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 24'($urandom));
        while (m_cnt % FT != 0) step(1'b0, 1'b0, '0);
        check("locked_at_boundary", 32'(locked), 32'd1);
        step(1'b0, 1'b0, '0);
        check("first_pixel", 32'(rgb_out), 32'hA00001);
        check("first_pixel_de", 32'(de_out), 32'd1);
        act_cnt = 1;
        guard   = 0;
        while (act_cnt < 11 && guard < 4 * HT) begin
            step(1'b0, 1'b0, '0);
            if (m_last_act) act_cnt++;
            guard++;
        end
        check("uf_reached", 32'(act_cnt), 32'd11);
        check("uf_pixel_zero", 32'(rgb_out), 32'd0);
        check("uf_flag", 32'(underflow), 32'd1);
        check("uf_unlocked", 32'(locked), 32'd0);
        check("uf_state_sync", 32'(dut.state), 32'(ST_SYNC));
        step(1'b1, 1'b1, 24'($urandom));
        for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 24'($urandom));
        while (m_cnt % FT != 0) step(1'b0, 1'b0, '0);
        check("relocked", 32'(locked), 32'd1);
        check("uf_sticky", 32'(underflow), 32'd1);
        repeat (20) step(1'b0, 1'b0, '0);

        // Continuous random stream with a stray sof mid-stream; order kept over 3 frames.
        do_reset(2);
        fed = 0;
        for (int i = 0; i < 4 * FT; i++) begin
            step((fed < 140) && ($urandom_range(0, 3) != 0), (fed == 0) || (fed == 40),
                 24'($urandom));
            if (m_obs_acc) fed++;
        end
        check("stream_no_underflow", 32'(underflow), 32'd0);
        check("stream_locked", 32'(locked), 32'd1);

        // Backpressure while waiting in FILL.
        do_reset(2);
        bp_acc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, i == 0, 24'($urandom));
            if (m_obs_acc) bp_acc++;
        end
        check("bp_accepted", 32'(bp_acc), 32'(DEPTH));
        check("bp_level", 32'(dut.level), 32'(DEPTH));
        check("bp_ready_low", 32'(rgb_in_ready), 32'd0);
        rgb_in_valid = 1'b0;
        while (m_cnt < FT + 20) step(1'b0, 1'b0, '0);

        // Reset pulse mid-line while running.
        do_reset(2);
        fed   = 0;
        guard = 0;
        while (!(m_mode == M_RUN && (m_cnt % HT) == 3 && ((m_cnt / HT) % VT) == 1)
               && guard < 3 * FT) begin
            step(1'b1, fed == 0, 24'($urandom));
            if (m_obs_acc) fed++;
            guard++;
        end
        check("mid_reset_point_reached", 32'(guard < 3 * FT), 32'd1);
        do_reset(1);
        for (int i = 0; i < 12; i++) step(1'b1, i == 2, 24'($urandom));
        while (m_cnt % FT != 0) step(1'b0, 1'b0, '0);
        repeat (HT) step(1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
